// File: rtl/lifo_arb_pkg.sv
// lifo_arb_pkg: opcode/state types and helpers shared by the LIFO arbiter files.
package lifo_arb_pkg;

    typedef enum logic [1:0] {
        REQ_EMPTY = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2,
        REQ_RW    = 2'd3
    } rq_code_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        RESP
    } state_t;

    localparam int unsigned CNT_W = 16;

    // Opcodes that take a word off the stack
    function automatic logic op_pops(input rq_code_t op);
        return (op == REQ_READ) || (op == REQ_RW);
    endfunction

    // Opcodes that put a word on the stack
    function automatic logic op_pushes(input rq_code_t op);
        return (op == REQ_WRITE) || (op == REQ_RW);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last grant + 1 with wrap.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDXW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDXW-1:0]  i_last,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDXW-1:0]  o_gnt_idx
);

    // First requester after the last grant wins
    always_comb begin
        logic            found;
        logic [IDXW-1:0] idx;
        int unsigned     pos;
        o_gnt     = '0;
        o_gnt_idx = '0;
        found     = 1'b0;
        idx       = '0;
        pos       = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            pos = (32'(i_last) + i) % N_REQ;
            idx = pos[IDXW-1:0];
            if (!found && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                o_gnt_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lifo_arbiter.sv
// lifo_arbiter: round-robin front end sharing one LIFO between N_REQ requesters,
// one operation in flight. Optional statistics under the LIFO_ARB_STATS_EN macro.
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [2*N_REQ-1:0]      req_op_i,
    input  logic [N_REQ*DWIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [N_REQ-1:0]        rsp_valid_o,
    output logic [DWIDTH-1:0]       rsp_data_o,
    output logic                    rsp_err_o,
    output logic                    lifo_wrreq_o,
    output logic                    lifo_rdreq_o,
    output logic [DWIDTH-1:0]       lifo_data_o,
    input  logic [DWIDTH-1:0]       lifo_q_i,
    input  logic                    lifo_empty_i,
    input  logic                    lifo_full_i,
    input  logic [AWIDTH:0]         lifo_usedw_i,
    output logic [N_REQ*CNT_W-1:0]  stat_ops_o,
    output logic [CNT_W-1:0]        stat_err_o,
    output logic [AWIDTH:0]         stat_max_fill_o
);

    localparam int unsigned IDXW = $clog2(N_REQ);

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    state_t            r_state, w_state_next;
    logic [IDXW-1:0]   r_rr, r_id, w_gnt_idx;
    rq_code_t          r_op, w_sel_op;
    logic [DWIDTH-1:0] w_sel_data, r_rsp_data, r_lifo_data;
    logic              r_err, w_err, w_idle, w_accept;
    logic              r_wrreq, r_rdreq, w_issue_wr, w_issue_rd;
    logic [N_REQ-1:0]  w_gnt;

    // Reset asserts asynchronously and releases two clocks later
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) r_rst_sync <= 2'b00;
        else           r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDXW  (IDXW)
    ) u_rr_arbiter (
        .i_req     (req_valid_i),
        .i_last    (r_rr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_idle   = (r_state == IDLE) && w_rst_n;
    assign w_accept = w_idle && (|w_gnt);

    // Select the granted requester's opcode and push data
    always_comb begin
        w_sel_op   = REQ_EMPTY;
        w_sel_data = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (w_gnt[k]) begin
                w_sel_op   = rq_code_t'(req_op_i[2*k +: 2]);
                w_sel_data = req_data_i[k*DWIDTH +: DWIDTH];
            end
        end
    end

    // Flags are checked at accept time; RW on a full stack is net-zero and allowed
    assign w_err      = (op_pops(w_sel_op) && lifo_empty_i) ||
                        ((w_sel_op == REQ_WRITE) && lifo_full_i);
    assign w_issue_wr = w_accept && !w_err && op_pushes(w_sel_op);
    assign w_issue_rd = w_accept && !w_err && op_pops(w_sel_op);

    // FSM state register
    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = ((w_sel_op == REQ_EMPTY) || w_err) ? RESP : ISSUE;
                end
            end
            ISSUE:   w_state_next = (r_op == REQ_WRITE) ? RESP : RD_WAIT;
            RD_WAIT: w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Capture the accepted request, launch strobes, collect pop data
    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rr        <= IDXW'(N_REQ - 1);
            r_id        <= '0;
            r_op        <= REQ_EMPTY;
            r_err       <= 1'b0;
            r_rsp_data  <= '0;
            r_wrreq     <= 1'b0;
            r_rdreq     <= 1'b0;
            r_lifo_data <= '0;
        end else begin
            r_wrreq     <= w_issue_wr;
            r_rdreq     <= w_issue_rd;
            r_lifo_data <= w_issue_wr ? w_sel_data : '0;
            if (w_accept) begin
                r_id       <= w_gnt_idx;
                r_rr       <= w_gnt_idx;
                r_op       <= w_sel_op;
                r_err      <= w_err;
                r_rsp_data <= '0;
            end else if (r_state == RD_WAIT) begin
                r_rsp_data <= lifo_q_i;
            end
        end
    end

    // FSM outputs
    always_comb begin
        req_ready_o = w_idle ? w_gnt : '0;
        rsp_valid_o = '0;
        rsp_data_o  = '0;
        rsp_err_o   = 1'b0;
        if (r_state == RESP) begin
            rsp_valid_o[r_id] = 1'b1;
            rsp_data_o        = r_rsp_data;
            rsp_err_o         = r_err;
        end
    end

    assign lifo_wrreq_o = r_wrreq;
    assign lifo_rdreq_o = r_rdreq;
    assign lifo_data_o  = r_lifo_data;

`ifdef LIFO_ARB_STATS_EN
    logic [CNT_W-1:0]  r_stat_ops [N_REQ];
    logic [CNT_W-1:0]  r_stat_err;
    logic [AWIDTH:0]   r_max_fill;

    // Saturating per-requester completion counts, error count and fill high-water mark
    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int k = 0; k < int'(N_REQ); k++) r_stat_ops[k] <= '0;
            r_stat_err <= '0;
            r_max_fill <= '0;
        end else begin
            if ((r_state == RESP) && (r_stat_ops[r_id] != '1)) begin
                r_stat_ops[r_id] <= r_stat_ops[r_id] + CNT_W'(1);
            end
            if ((r_state == RESP) && r_err && (r_stat_err != '1)) begin
                r_stat_err <= r_stat_err + CNT_W'(1);
            end
            if (lifo_usedw_i > r_max_fill) r_max_fill <= lifo_usedw_i;
        end
    end

    for (genvar k = 0; k < N_REQ; k++) begin : g_stat_ops
        assign stat_ops_o[k*CNT_W +: CNT_W] = r_stat_ops[k];
    end
    assign stat_err_o      = r_stat_err;
    assign stat_max_fill_o = r_max_fill;
`else
    // Fill level only feeds the statistics block
    logic w_unused_usedw;
    assign w_unused_usedw  = ^lifo_usedw_i;
    assign stat_ops_o      = '0;
    assign stat_err_o      = '0;
    assign stat_max_fill_o = '0;
`endif

endmodule

// File: tb/tb_lifo_arbiter.sv
// tb_lifo_arbiter: directed and random traffic against a queue-based model of the arbiter,
// with a behavioural stack standing in for the LIFO core.
module tb_lifo_arbiter;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam logic [1:0] OP_E = 2'd0, OP_R = 2'd1, OP_W = 2'd2, OP_RW = 2'd3;

    logic            clk = 1'b0;
    logic            arst_n;
    logic [N-1:0]    req_valid;
    logic [2*N-1:0]  req_op;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_data, lifo_data, lifo_q;
    logic            rsp_err, lifo_wrreq, lifo_rdreq, lifo_empty, lifo_full;
    logic [AW:0]     lifo_usedw, stat_max_fill;
    logic [N*16-1:0] stat_ops;
    logic [15:0]     stat_err;

    int n_checks = 0;
    int n_pass   = 0;

    lifo_arbiter #(.N_REQ(N), .DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i           (clk),
        .arst_n_i        (arst_n),
        .req_valid_i     (req_valid),
        .req_op_i        (req_op),
        .req_data_i      (req_data),
        .req_ready_o     (req_ready),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .rsp_err_o       (rsp_err),
        .lifo_wrreq_o    (lifo_wrreq),
        .lifo_rdreq_o    (lifo_rdreq),
        .lifo_data_o     (lifo_data),
        .lifo_q_i        (lifo_q),
        .lifo_empty_i    (lifo_empty),
        .lifo_full_i     (lifo_full),
        .lifo_usedw_i    (lifo_usedw),
        .stat_ops_o      (stat_ops),
        .stat_err_o      (stat_err),
        .stat_max_fill_o (stat_max_fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Behavioural LIFO core: q one cycle after rdreq, flags follow the registered count
    logic [DW-1:0] mem [DEPTH];
    int            env_cnt = 0;
    always @(posedge clk) begin
        if (lifo_rdreq && lifo_wrreq) begin
            if (env_cnt > 0) begin
                lifo_q <= mem[env_cnt-1];
                mem[env_cnt-1] <= lifo_data;
            end
        end else if (lifo_rdreq) begin
            if (env_cnt > 0) begin
                lifo_q  <= mem[env_cnt-1];
                env_cnt <= env_cnt - 1;
            end
        end else if (lifo_wrreq) begin
            if (env_cnt < DEPTH) begin
                mem[env_cnt] <= lifo_data;
                env_cnt      <= env_cnt + 1;
            end
        end
    end
    assign lifo_empty = (env_cnt == 0);
    assign lifo_full  = (env_cnt == DEPTH);
    assign lifo_usedw = env_cnt[AW:0];

    // Reference model: a queue stack plus the cycle numbers at which things must happen
    logic [DW-1:0] m_stack [$];
    int            m_rr = N - 1;
    longint        cyc = 0, m_acc_cyc = -100, m_rsp_cyc = -100, m_free_cyc = 0;
    logic          m_wr = 0, m_rd = 0, m_err = 0;
    logic [DW-1:0] m_wdata = 0, m_rdata = 0;
    int            m_id = 0;
    logic [N-1:0]  m_acc_mask = 0;

    logic [N-1:0]  e_ready, e_rspv;
    logic          e_wr, e_rd, e_err;
    logic [DW-1:0] e_ldata, e_rspd;
    int            e_k, e_lat;
    logic [1:0]    e_op;
    logic [DW-1:0] e_d;

    always @(negedge clk) begin
        e_ready = '0; e_rspv = '0; e_wr = 0; e_rd = 0; e_err = 0; e_ldata = '0; e_rspd = '0;
        if (!arst_n) begin
            m_rr = N - 1; m_acc_cyc = -100; m_rsp_cyc = -100; m_free_cyc = 0;
        end else begin
            if (cyc >= m_free_cyc) begin
                for (int i = 1; i <= N; i++) begin
                    e_k = (m_rr + i) % N;
                    if (e_ready == '0 && req_valid[e_k]) e_ready[e_k] = 1'b1;
                end
            end
            e_wr    = (cyc == m_acc_cyc + 1) && m_wr;
            e_rd    = (cyc == m_acc_cyc + 1) && m_rd;
            e_ldata = e_wr ? m_wdata : '0;
            if (cyc == m_rsp_cyc) begin
                e_rspv[m_id] = 1'b1;
                e_rspd       = m_rdata;
                e_err        = m_err;
            end
        end
        check("ready", req_ready, e_ready);
        check("strobes", {lifo_wrreq, lifo_rdreq}, {e_wr, e_rd});
        check("lifo_data", lifo_data, e_ldata);
        check("rsp", {rsp_valid, rsp_err, rsp_data}, {e_rspv, e_err, e_rspd});
        m_acc_mask = e_ready;
        if (e_ready != '0) begin
            for (int i = 0; i < N; i++) if (e_ready[i]) e_k = i;
            e_op  = req_op[2*e_k +: 2];
            e_d   = req_data[e_k*DW +: DW];
            m_err = ((e_op == OP_R || e_op == OP_RW) && m_stack.size() == 0) ||
                    (e_op == OP_W && m_stack.size() == DEPTH);
            m_id = e_k; m_rdata = '0; m_wdata = e_d;
            m_wr = !m_err && (e_op == OP_W || e_op == OP_RW);
            m_rd = !m_err && (e_op == OP_R || e_op == OP_RW);
            if (!m_err) begin
                if (e_op == OP_R) m_rdata = m_stack.pop_back();
                else if (e_op == OP_W) m_stack.push_back(e_d);
                else if (e_op == OP_RW) begin
                    m_rdata = m_stack[m_stack.size()-1];
                    m_stack[m_stack.size()-1] = e_d;
                end
            end
            e_lat = (e_op == OP_E || m_err) ? 1 : (e_op == OP_W) ? 2 : 3;
            m_acc_cyc = cyc; m_rsp_cyc = cyc + e_lat; m_free_cyc = cyc + e_lat + 1; m_rr = e_k;
        end
        cyc++;
    end

    task automatic do_reset();
        @(posedge clk); #1 arst_n = 0; req_valid = '0;
        repeat (3) @(posedge clk);
        #1 arst_n = 1;
        repeat (4) @(posedge clk);
    endtask

    // Issue one request, wait for its grant and its response
    task automatic do_op(input int id, input logic [1:0] op, input logic [DW-1:0] d,
                         output logic [DW-1:0] rd, output logic er);
        bit got;
        @(posedge clk); #1;
        req_valid[id] = 1'b1; req_op[2*id +: 2] = op; req_data[id*DW +: DW] = d;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk); if (req_ready[id]) got = 1;
        end
        check("accepted", got, 1);
        @(posedge clk); #1 req_valid[id] = 1'b0;
        got = 0; rd = '0; er = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid[id]) begin got = 1; rd = rsp_data; er = rsp_err; end
        end
        check("responded", got, 1);
    endtask

    function automatic logic [1:0] pick_op(input int mode);
        int r;
        r = $urandom_range(0, 99);
        if (r < 10) return OP_E;
        if (mode == 0) return (r < 70) ? OP_R : (r < 85) ? OP_W : OP_RW;
        if (mode == 1) return (r < 30) ? OP_R : (r < 85) ? OP_W : OP_RW;
        return (r < 45) ? OP_R : (r < 80) ? OP_W : OP_RW;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        logic          er;
        int            gid;
        bit            got;
        int            exp_order [5] = '{0, 1, 2, 3, 0};
        logic [DW-1:0] exp_mem [5] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0200};

        arst_n = 0; req_valid = '0; req_op = '0; req_data = '0;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", {req_ready, rsp_valid, rsp_err, lifo_wrreq, lifo_rdreq}, 0);
        arst_n = 1;
        repeat (4) @(posedge clk);

`ifdef LIFO_ARB_STATS_EN
        do_op(3, OP_R, 16'h0, rd, er);
        for (int i = 0; i < 3; i++) do_op(1, OP_W, 16'h0040 + 16'(i), rd, er);
        repeat (2) @(posedge clk);
        #1 check("stat_ops1", stat_ops[1*16 +: 16], 3);
        check("stat_ops3", stat_ops[3*16 +: 16], 1);
        check("stat_err", stat_err, 1);
        check("stat_max_fill", stat_max_fill, 3);
        for (int i = 0; i < 3; i++) do_op(0, OP_R, 16'h0, rd, er);
        do_reset();
`endif

        // Single write from requester 0
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_op[1:0] = OP_W; req_data[15:0] = 16'hA5A5;
        #1 check("A_ready", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        check("A_wrreq", {lifo_wrreq, lifo_rdreq, lifo_data}, {1'b1, 1'b0, 16'hA5A5});
        @(posedge clk); #1 check("A_rsp", {rsp_valid, rsp_err}, {4'b0001, 1'b0});
        @(posedge clk); #1 check("A_usedw", lifo_usedw, 1);

        // Pops come back in reverse push order, then underflow
        do_op(0, OP_R, 16'h0, rd, er); check("B_pop_a5", {er, rd}, {1'b0, 16'hA5A5});
        for (int i = 1; i <= 3; i++) do_op(1, OP_W, 16'(i), rd, er);
        for (int i = 3; i >= 1; i--) begin
            do_op(2, OP_R, 16'h0, rd, er); check("B_pop", {er, rd}, {1'b0, 16'(i)});
        end
        do_op(2, OP_R, 16'h0, rd, er); check("B_underflow", {er, rd}, {1'b1, 16'h0});
        do_op(3, OP_E, 16'hFFFF, rd, er); check("B_empty_op", {er, rd}, {1'b0, 16'h0});

        // All four hold writes: fair rotation
        for (int k = 0; k < N; k++) begin
            req_op[2*k +: 2] = OP_W; req_data[k*DW +: DW] = 16'h0100 + 16'(k);
        end
        @(posedge clk); #1 req_valid = '1;
        for (int g = 0; g < 5; g++) begin
            got = 0; gid = -1;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (req_ready != '0) begin
                    got = 1;
                    for (int k = 0; k < N; k++) if (req_ready[k]) gid = k;
                end
            end
            check("C_grant", gid, exp_order[g]);
            @(posedge clk); #1;
            if (g < 4 && gid >= 0) req_data[gid*DW +: DW] = 16'h0200 + 16'(gid);
            else req_valid = '0;
        end
        repeat (5) @(posedge clk);
        #1 check("C_count", env_cnt, 5);
        for (int i = 0; i < 5; i++) check("C_mem", mem[i], exp_mem[i]);

        // Fill to full, overflow, RW on full
        for (int i = 0; i < 251; i++) do_op(1, OP_W, 16'h1000 + 16'(i), rd, er);
        do_op(1, OP_W, 16'hDEAD, rd, er); check("D_overflow", {er, rd}, {1'b1, 16'h0});
        do_op(0, OP_RW, 16'h0077, rd, er); check("D_rw_full", {er, rd}, {1'b0, 16'h10FA});
        repeat (2) @(posedge clk);
        #1 check("D_usedw", lifo_usedw, 256);
        do_op(3, OP_R, 16'h0, rd, er); check("D_pop_rw", {er, rd}, {1'b0, 16'h0077});

        // Reset while a read waits for data
        @(posedge clk); #1 req_valid[1] = 1'b1; req_op[3:2] = OP_R;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); if (req_ready[1]) got = 1;
        end
        check("E_accepted", got, 1);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        @(posedge clk); #1 arst_n = 0;
        #1 check("E_async_clear", {req_ready, rsp_valid, rsp_err, lifo_wrreq, lifo_rdreq,
                                   rsp_data, lifo_data}, 0);
        repeat (3) @(posedge clk);
        #1 arst_n = 1;
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) req_op[2*k +: 2] = OP_E;
        req_valid = '1;
        #1 check("E_first_grant", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);

        // Random traffic in three phases: drain-heavy, fill-heavy, mixed
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                if (m_acc_mask[k] || !req_valid[k]) begin
                    if ($urandom_range(0, 99) < 40) begin
                        req_valid[k] = 1'b1;
                        req_op[2*k +: 2] = pick_op(c / 1000);
                        req_data[k*DW +: DW] = 16'($urandom);
                    end else begin
                        req_valid[k] = 1'b0;
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    req_valid[k] = 1'b0;
                end
            end
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (10) @(posedge clk);
        #1 check("F_stack_depth", env_cnt, m_stack.size());

`ifndef LIFO_ARB_STATS_EN
        check("stats_tied_zero", {stat_ops, stat_err, stat_max_fill}, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lifo_arbiter.md
Name: lifo_arbiter

Overview:
- Shares one single-port-command LIFO (stack) between N_REQ requesters.
- Each requester issues an opcode: empty, read (pop), write (push) or read-write (pop+push).
- Round-robin arbitration with one operation in flight at a time.
- Sequences LIFO read/write strobes, checks full/empty before issuing, and returns pop data or an error to the granted requester.
- Sits between client logic and the lifo core instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DWIDTH, 16, LIFO data width
- AWIDTH, 8, LIFO address width; usedw width is AWIDTH+1

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  N_REQ  per-requester request valid
- req_op_i  in  2*N_REQ  per-requester opcode, requester k at [2k+1:2k]: 0 EMPTY, 1 READ, 2 WRITE, 3 RW
- req_data_i  in  N_REQ*DWIDTH  per-requester push data, requester k at [k*DWIDTH +: DWIDTH]
- req_ready_o  out  N_REQ  one-hot grant; request accepted when valid&ready
- rsp_valid_o  out  N_REQ  one-hot response strobe to the owning requester
- rsp_data_o  out  DWIDTH  popped word (READ/RW); 0 otherwise
- rsp_err_o  out  1  operation rejected (overflow/underflow)
- lifo_wrreq_o  out  1  LIFO push strobe
- lifo_rdreq_o  out  1  LIFO pop strobe
- lifo_data_o  out  DWIDTH  LIFO write data
- lifo_q_i  in  DWIDTH  LIFO read data, valid 1 cycle after rdreq
- lifo_empty_i  in  1  LIFO empty flag (registered in LIFO)
- lifo_full_i  in  1  LIFO full flag (registered in LIFO)
- lifo_usedw_i  in  AWIDTH+1  LIFO fill level

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE; all outputs 0; rr pointer = N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, RD_WAIT, RESP.

IDLE:
- req_ready_o is combinational: one-hot to the first valid requester searching from rr+1 with wrap.
- req_ready_o is 0 in every other state.
- On accept at cycle T:
  - capture id, op and data; rr <= id.
  - Check flags at T: READ or RW with empty_i=1 is an error; WRITE with full_i=1 is an error.
  - RW with full is legal (net zero change).

Transitions:
- EMPTY op or error -> RESP at T+1, no LIFO strobe.
- Otherwise -> ISSUE at T+1.

ISSUE (T+1):
- Registered strobes:
  - WRITE: wrreq_o=1, data_o=captured data.
  - READ: rdreq_o=1.
  - RW: rdreq_o=1 and wrreq_o=1 in the same cycle; the LIFO returns the old top and the new word replaces it.
- WRITE -> RESP at T+2; READ/RW -> RD_WAIT at T+2.

RD_WAIT (T+2):
- Register lifo_q_i into the response data -> RESP at T+3.

RESP:
- rsp_valid_o[id]=1 for exactly one cycle, with rsp_data_o and rsp_err_o.
- -> IDLE; a new accept is possible in the same cycle RESP drops.

Latency, accept to rsp_valid:
- EMPTY/error: 1 cycle
- WRITE: 2 cycles
- READ/RW: 3 cycles
- Throughput: one op per latency+1 cycles.

Other rules:
- Requests held without ready must stay stable; a requester dropping valid loses nothing.
- Flags seen in IDLE always reflect the previous op, because the LIFO updates its flags one cycle after the strobe.
- lifo_usedw_i is used only by the optional feature.
- Reset mid-operation: the in-flight op is abandoned with no response; strobes clear immediately.

Optional Feature:
LIFO_ARB_STATS_EN
- Defined: adds outputs stat_ops_o (N_REQ*16, per-requester completed-op counters, saturating at 16'hFFFF), stat_err_o (16, saturating error count) and stat_max_fill_o (AWIDTH+1, high-water mark of lifo_usedw_i). All are cleared by reset.
- Undefined: the stat ports still exist, tied to 0, with no counter logic.

Decomposition:
- Shared package lifo_arb_pkg holds:
  - typedef enum logic[1:0] rq_code_t {REQ_EMPTY, REQ_READ, REQ_WRITE, REQ_RW}
  - typedef enum state_t {IDLE, ISSUE, RD_WAIT, RESP}
  - localparam CNT_W=16
- One sub-module: rr_arbiter (N_REQ request vector plus last-grant pointer in, one-hot grant out; combinational).

Test Plan:
- Reset, then requester 0 WRITE 16'hA5A5 -> ready0 at T, wrreq at T+1, rsp_valid[0]=1, err=0 at T+2; usedw=1.
- Requester 2 READ after pushes 1,2,3 -> rdreq at T+1, rsp_valid[2] at T+3 with data 3, then 2, then 1; a fourth READ gives err=1 with no rdreq.
- All 4 requesters hold WRITE valid continuously -> grant order 0,1,2,3,0; each gets exactly one rsp; LIFO contents match.
- Fill to 2^AWIDTH=256, then WRITE -> err=1, no wrreq; RW 16'h0077 -> returns the old top, usedw stays 256, next READ returns 16'h0077.
- Assert arst_n_i low in RD_WAIT of a READ -> all outputs 0 asynchronously, no rsp; after release requester 0 is granted first.
- With LIFO_ARB_STATS_EN: 3 writes by req1 and 1 underflow by req3 -> stat_ops[1]=3, stat_ops[3]=1, stat_err=1, stat_max_fill=3.
